// File: rtl/tmds_encoder_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder_multi_if
// Summary  : Bundles the mode, lane data and status signals of the
//            multi-lane TMDS encoder. The master side is the packet/video mux
//            and the slave side is the encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface tmds_encoder_multi_if #(
  parameter int NUM_LANES = 3
);

  logic                     en;
  logic [2:0]               mode;
  logic [8*NUM_LANES-1:0]   video_data;
  logic [4*NUM_LANES-1:0]   data_island_data;
  logic [2*NUM_LANES-1:0]   control_data;
  logic                     clear_err;
  logic [10*NUM_LANES-1:0]  tmds;
  logic                     out_valid;
  logic [5*NUM_LANES-1:0]   disparity;
  logic [NUM_LANES-1:0]     disparity_err;

  modport master (
    output en, mode, video_data, data_island_data, control_data, clear_err,
    input  tmds, out_valid, disparity, disparity_err
  );

  modport slave (
    input  en, mode, video_data, data_island_data, control_data, clear_err,
    output tmds, out_valid, disparity, disparity_err
  );

endinterface
`default_nettype wire

// File: rtl/tmds_encoder_multi.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder_multi
// Summary  : NUM_LANES-wide TMDS encoder with a two-stage registered
//            pipeline. Stage 1 does the transition-minimising q_m step, and
//            stage 2 does DC balancing and symbol selection for control,
//            video, guard-band and TERC4 periods. Each lane tracks its own
//            running disparity and has a sticky limit flag.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_encoder_multi #(
  parameter int NUM_LANES  = 3,
  parameter int DISP_LIMIT = 10
) (
  input wire                  clk_pixel,
  input wire                  reset_n,
  tmds_encoder_multi_if.slave bus
);

  localparam logic [2:0] c_MODE_CTRL  = 3'd0;
  localparam logic [2:0] c_MODE_VIDEO = 3'd1;
  localparam logic [2:0] c_MODE_VGB   = 3'd2;
  localparam logic [2:0] c_MODE_TERC4 = 3'd3;
  localparam logic [2:0] c_MODE_DGB   = 3'd4;

  localparam logic [9:0] c_SYM_RESET  = 10'b1101010100;
  localparam logic [9:0] c_GB_A       = 10'b1011001100;
  localparam logic [9:0] c_GB_B       = 10'b0100110011;
  localparam logic [4:0] c_LIMIT      = 5'(DISP_LIMIT);

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] d);
    logic [9:0] s;
    case (d)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Lane 0 data guard band carries HSYNC/VSYNC, i.e. TERC4 codes 0xC..0xF.
  function automatic logic [9:0] dgb0_sym(input logic [1:0] c);
    return terc4_sym({2'b11, c});
  endfunction

  logic [2:0]             r_mode;
  logic [2*NUM_LANES-1:0] r_ctrl;
  logic [4*NUM_LANES-1:0] r_terc;
  logic                   r_primed;
  logic                   r_out_valid;

  // Stage 1 shared fields, plus the two-edge fill tracker behind out_valid.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_mode      <= c_MODE_CTRL;
      r_ctrl      <= '0;
      r_terc      <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.en) begin
      r_mode      <= bus.mode;
      r_ctrl      <= bus.control_data;
      r_terc      <= bus.data_island_data;
      r_primed    <= 1'b1;
      r_out_valid <= r_primed;
    end
  end

  assign bus.out_valid = r_out_valid;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam int c_CN = k % 3;

    logic [7:0]        w_d;
    logic [3:0]        w_n1d;
    logic              w_use_xnor;
    logic              w_bit;
    logic [8:0]        w_qm;
    logic [8:0]        r_qm;
    logic [3:0]        r_n1;
    logic signed [5:0] w_n1s;
    logic signed [5:0] w_n0s;
    logic signed [5:0] w_add;
    logic [9:0]        w_sym;
    logic signed [4:0] w_acc_nxt;
    logic [4:0]        w_mag;
    logic [9:0]        r_tmds;
    logic signed [4:0] r_acc;
    logic              r_err;

    assign w_d = bus.video_data[8*k +: 8];

    // Transition-minimising step: XOR or XNOR chain chosen by input weight.
    always_comb begin
      w_n1d      = popcnt8(w_d);
      w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_d[0]);
      w_bit      = w_d[0];
      w_qm       = '0;
      w_qm[0]    = w_d[0];
      for (int i = 1; i < 8; i++) begin
        w_bit   = w_use_xnor ? ~(w_bit ^ w_d[i]) : (w_bit ^ w_d[i]);
        w_qm[i] = w_bit;
      end
      w_qm[8] = ~w_use_xnor;
    end

    // Stage 1 per-lane q_m and its ones count, so stage 2 avoids a popcount.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
        r_qm <= '0;
        r_n1 <= '0;
      end else if (bus.en) begin
        r_qm <= w_qm;
        r_n1 <= popcnt8(w_qm[7:0]);
      end
    end

    // Stage 2 symbol selection and disparity bookkeeping. Reserved modes
    // hold the previous symbol. Every non-video period restarts balancing.
    always_comb begin
      w_n1s     = $signed({2'b00, r_n1});
      w_n0s     = 6'sd8 - w_n1s;
      w_add     = '0;
      w_sym     = r_tmds;
      w_acc_nxt = '0;
      case (r_mode)
        c_MODE_VIDEO: begin
          if ((r_acc == 5'sd0) || (w_n1s == w_n0s)) begin
            w_sym = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_add = r_qm[8] ? (w_n1s - w_n0s) : (w_n0s - w_n1s);
          end else if (((r_acc > 5'sd0) && (w_n1s > w_n0s)) ||
                       ((r_acc < 5'sd0) && (w_n1s < w_n0s))) begin
            w_sym = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_add = (w_n0s - w_n1s) + (r_qm[8] ? 6'sd2 : 6'sd0);
          end else begin
            w_sym = {1'b0, r_qm[8], r_qm[7:0]};
            w_add = (w_n1s - w_n0s) - (r_qm[8] ? 6'sd0 : 6'sd2);
          end
          w_acc_nxt = r_acc + w_add[4:0];
        end
        c_MODE_CTRL:  w_sym = ctrl_sym(r_ctrl[2*k +: 2]);
        c_MODE_TERC4: w_sym = terc4_sym(r_terc[4*k +: 4]);
        c_MODE_VGB:   w_sym = (c_CN == 1) ? c_GB_B : c_GB_A;
        c_MODE_DGB:   w_sym = (c_CN == 0) ? dgb0_sym(r_ctrl[2*k +: 2]) : c_GB_B;
        default:      w_sym = r_tmds;
      endcase
      w_mag = w_acc_nxt[4] ? (5'd0 - w_acc_nxt) : w_acc_nxt;
    end

    // Stage 2 registers. A new limit violation beats a simultaneous clear.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
        r_tmds <= c_SYM_RESET;
        r_acc  <= '0;
        r_err  <= 1'b0;
      end else if (bus.en) begin
        r_tmds <= w_sym;
        r_acc  <= w_acc_nxt;
        r_err  <= (w_mag > c_LIMIT) | (r_err & ~bus.clear_err);
      end
    end

    assign bus.tmds[10*k +: 10]    = r_tmds;
    assign bus.disparity[5*k +: 5] = r_acc;
    assign bus.disparity_err[k]    = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_encoder_multi
// Summary  : Self-checking bench for tmds_encoder_multi. Two instances share
//            the same stimulus with different disparity limits. They are
//            compared against a behavioural model that keeps the raw
//            accepted pixel and re-derives every symbol from the encoding
//            rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_encoder_multi;

  localparam int NL    = 3;
  localparam int LIM_A = 10;
  localparam int LIM_B = 1;

  localparam logic [9:0] RST_SYM = 10'b1101010100;
  localparam logic [9:0] GB_A    = 10'b1011001100;
  localparam logic [9:0] GB_B    = 10'b0100110011;
  localparam logic [9:0] CTRL_TBL [4] = '{10'b1101010100, 10'b0010101011,
                                          10'b0101010100, 10'b1010101011};
  localparam logic [9:0] DGB0_TBL [4] = '{10'b1010001110, 10'b1001110001,
                                          10'b0101100011, 10'b1011000011};
  localparam logic [9:0] TERC_TBL [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;

  logic              en;
  logic [2:0]        mode;
  logic [8*NL-1:0]   vd;
  logic [4*NL-1:0]   di;
  logic [2*NL-1:0]   cd;
  logic              clear_err;

  int vectors     = 0;
  int miscompares = 0;

  tmds_encoder_multi_if #(.NUM_LANES(NL)) bus_a ();
  tmds_encoder_multi_if #(.NUM_LANES(NL)) bus_b ();

  assign bus_a.en = en;   assign bus_a.mode = mode;   assign bus_a.video_data = vd;
  assign bus_a.data_island_data = di;   assign bus_a.control_data = cd;
  assign bus_a.clear_err = clear_err;
  assign bus_b.en = en;   assign bus_b.mode = mode;   assign bus_b.video_data = vd;
  assign bus_b.data_island_data = di;   assign bus_b.control_data = cd;
  assign bus_b.clear_err = clear_err;

  tmds_encoder_multi #(.NUM_LANES(NL), .DISP_LIMIT(LIM_A)) dut_a (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus_a)
  );

  tmds_encoder_multi #(.NUM_LANES(NL), .DISP_LIMIT(LIM_B)) dut_b (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus_b)
  );

  always #5 clk_pixel = ~clk_pixel;

  // ---------------- reference model ----------------
  logic [2:0]      m_mode;
  logic [8*NL-1:0] m_vd;
  logic [4*NL-1:0] m_di;
  logic [2*NL-1:0] m_cd;
  logic [9:0]      m_tmds  [NL];
  int              m_acc   [NL];
  bit              m_err_a [NL];
  bit              m_err_b [NL];
  int              m_edges;

  function automatic int wrap5(input int v);
    return (((v % 32) + 48) % 32) - 16;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_mode = 3'd0; m_vd = '0; m_di = '0; m_cd = '0; m_edges = 0;
    for (int k = 0; k < NL; k++) begin
      m_tmds[k] = RST_SYM; m_acc[k] = 0; m_err_a[k] = 0; m_err_b[k] = 0;
    end
  endtask

  // One enabled pixel-clock edge: emit symbols for the held pixel, then accept the new one.
  task automatic model_edge();
    if (!en) return;
    for (int k = 0; k < NL; k++) begin
      logic [7:0] d;
      logic [7:0] qm;
      bit         xn, q8;
      int         n1d, n1, n0, acc;
      logic [9:0] sym;
      acc = m_acc[k];
      sym = m_tmds[k];
      case (m_mode)
        3'd0: sym = CTRL_TBL[m_cd[2*k +: 2]];
        3'd1: begin
          d   = m_vd[8*k +: 8];
          n1d = $countones(d);
          xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
          qm[0] = d[0];
          for (int i = 1; i < 8; i++)
            qm[i] = xn ? (qm[i-1] == d[i]) : (qm[i-1] != d[i]);
          q8 = !xn;
          n1 = $countones(qm);
          n0 = 8 - n1;
          if (acc == 0 || n1 == n0) begin
            sym = {!q8, q8, q8 ? qm : ~qm};
            acc = acc + (q8 ? (n1 - n0) : (n0 - n1));
          end else if ((acc > 0 && n1 > n0) || (acc < 0 && n1 < n0)) begin
            sym = {1'b1, q8, ~qm};
            acc = acc + (n0 - n1) + (q8 ? 2 : 0);
          end else begin
            sym = {1'b0, q8, qm};
            acc = acc + (n1 - n0) - (q8 ? 0 : 2);
          end
        end
        3'd2: sym = (k % 3 == 1) ? GB_B : GB_A;
        3'd3: sym = TERC_TBL[m_di[4*k +: 4]];
        3'd4: sym = (k % 3 == 0) ? DGB0_TBL[m_cd[2*k +: 2]] : GB_B;
        default: sym = m_tmds[k];
      endcase
      if (m_mode != 3'd1) acc = 0;
      acc = wrap5(acc);
      m_tmds[k]  = sym;
      m_acc[k]   = acc;
      m_err_a[k] = (iabs(acc) > LIM_A) || (m_err_a[k] && !clear_err);
      m_err_b[k] = (iabs(acc) > LIM_B) || (m_err_b[k] && !clear_err);
    end
    m_mode = mode; m_vd = vd; m_di = di; m_cd = cd;
    if (m_edges < 2) m_edges++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    logic [10*NL-1:0] et;
    logic [5*NL-1:0]  ed;
    logic [NL-1:0]    ea, eb;
    for (int k = 0; k < NL; k++) begin
      et[10*k +: 10] = m_tmds[k];
      ed[5*k +: 5]   = 5'(m_acc[k]);
      ea[k]          = m_err_a[k];
      eb[k]          = m_err_b[k];
    end
    check({where, ":tmds_a"}, 64'(bus_a.tmds), 64'(et));
    check({where, ":tmds_b"}, 64'(bus_b.tmds), 64'(et));
    check({where, ":disp_a"}, 64'(bus_a.disparity), 64'(ed));
    check({where, ":err_a"},  64'(bus_a.disparity_err), 64'(ea));
    check({where, ":err_b"},  64'(bus_b.disparity_err), 64'(eb));
    check({where, ":valid"},  64'(bus_a.out_valid), 64'(m_edges >= 2));
  endtask

  task automatic cycle(input string where);
    @(posedge clk_pixel);
    #1;
    model_edge();
    check_all(where);
  endtask

  // Reset pulse placed between edges, checked while it is still asserted.
  task automatic async_reset(input string where);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    check({where, ":valid0"}, 64'(bus_a.out_valid), 64'd0);
    #1 reset_n = 1'b1;
  endtask

  task automatic rand_pixel();
    for (int k = 0; k < NL; k++) begin
      vd[8*k +: 8] = 8'($urandom());
      di[4*k +: 4] = 4'($urandom());
      cd[2*k +: 2] = 2'($urandom());
    end
  endtask

  initial begin
    en = 1'b0; mode = 3'd0; vd = '0; di = '0; cd = '0; clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_pixel);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // control symbols after reset, fill latency
    en = 1'b1; mode = 3'd0; cd = 6'b000001;
    cycle("ctl1");
    cycle("ctl2");
    check("ctl_lane0", 64'(bus_a.tmds[9:0]), 64'(10'b0010101011));
    check("ctl_lane1", 64'(bus_a.tmds[19:10]), 64'(RST_SYM));
    check("ctl_valid", 64'(bus_a.out_valid), 64'd1);

    // two all-zero video pixels
    mode = 3'd1; vd = '0; cd = '0;
    cycle("vid1");
    cycle("vid2");
    check("vid_sym1", 64'(bus_a.tmds[9:0]), 64'(10'b0100000000));
    check("vid_disp1", 64'(bus_a.disparity[4:0]), 64'(5'b11000));
    mode = 3'd0;
    cycle("vid3");
    check("vid_sym2", 64'(bus_a.tmds[9:0]), 64'(10'b1111111111));
    check("vid_disp2", 64'(bus_a.disparity[4:0]), 64'(5'd2));
    check("lim1_set", 64'(bus_b.disparity_err[0]), 64'd1);
    clear_err = 1'b1;
    cycle("clr");
    check("lim1_clr", 64'(bus_b.disparity_err[0]), 64'd0);
    clear_err = 1'b0;

    // video -> video guard band -> data guard band
    mode = 3'd1; rand_pixel();
    cycle("gb1");
    mode = 3'd2;
    cycle("gb2");
    mode = 3'd4; cd = 6'b000010;
    cycle("gb3");
    check("vgb_lane0", 64'(bus_a.tmds[9:0]), 64'(GB_A));
    check("vgb_lane1", 64'(bus_a.tmds[19:10]), 64'(GB_B));
    mode = 3'd0;
    cycle("gb4");
    check("dgb_lane0", 64'(bus_a.tmds[9:0]), 64'(10'b0101100011));
    check("dgb_lane1", 64'(bus_a.tmds[19:10]), 64'(GB_B));
    check("dgb_disp0", 64'(bus_a.disparity[4:0]), 64'd0);

    // TERC4 sweep then a reserved-mode insertion
    mode = 3'd3;
    for (int v = 0; v < 16; v++) begin
      di = {NL{4'(v)}};
      cycle("terc");
    end
    mode = 3'd5;
    cycle("rsv1");
    mode = 3'd3; di = {NL{4'h7}};
    cycle("rsv2");
    check("rsv_hold", 64'(bus_a.tmds[9:0]), 64'(TERC_TBL[15]));
    cycle("rsv3");
    check("rsv_after", 64'(bus_a.tmds[9:0]), 64'(TERC_TBL[7]));

    // stall in the middle of video, with clear_err asserted while stalled
    mode = 3'd1;
    for (int i = 0; i < 4; i++) begin rand_pixel(); cycle("pre_stall"); end
    en = 1'b0; clear_err = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_pixel(); cycle("stall"); end
    en = 1'b1; clear_err = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_pixel(); cycle("post_stall"); end

    // asynchronous reset mid-video
    async_reset("areset");
    mode = 3'd1;
    for (int i = 0; i < 3; i++) begin rand_pixel(); cycle("after_rst"); end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(0, 9) != 0);
      clear_err = ($urandom_range(0, 15) == 0);
      mode      = ($urandom_range(0, 15) < 9) ? 3'd1 : 3'($urandom_range(0, 7));
      rand_pixel();
      if ($urandom_range(0, 7) == 0) vd = {NL{8'h00}};
      if ($urandom_range(0, 7) == 0) vd = {NL{8'hFF}};
      cycle("rand");
      if (n % 500 == 250) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tmds_encoder_multi.md
Name: tmds_encoder_multi

Overview:
Parametrised successor to the single-lane TMDS channel encoder. Encodes NUM_LANES TMDS lanes in parallel through a registered two-stage pipeline, with a shared mode bus and a clock enable. Adds an asynchronous active-low reset, per-lane running-disparity observation, and a sticky disparity-limit monitor. Sits between the HDMI packet/video mux and the serialisers; one instance replaces the three per-channel encoders.

Parameters:
NUM_LANES, 3, number of lanes encoded; lane k uses guard-band personality CN = k mod 3.
DISP_LIMIT, 10, magnitude (1..15) above which a lane's running disparity flags an error.

Ports:
clk_pixel  in  1  pixel clock; all state on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
en  in  1  pipeline advance; when low all state holds.
mode  in  3  0=control, 1=video, 2=video guard band, 3=TERC4 data island, 4=data guard band, 5..7 reserved.
video_data  in  8*NUM_LANES  lane k at [8k+7:8k].
data_island_data  in  4*NUM_LANES  lane k at [4k+3:4k].
control_data  in  2*NUM_LANES  lane k at [2k+1:2k].
clear_err  in  1  synchronous clear of disparity_err (qualified by en).
tmds  out  10*NUM_LANES  encoded symbol, lane k at [10k+9:10k].
out_valid  out  1  high once pipeline holds data accepted since reset.
disparity  out  5*NUM_LANES  signed running disparity per lane, as used for the current tmds symbol.
disparity_err  out  NUM_LANES  sticky per-lane limit flag.

Behaviour:
- Reset (reset_n low, async): every tmds lane = 10'b1101010100; disparity = 0; disparity_err = 0; out_valid = 0; stage-1 registers = mode 0, control 00, other data 0.
- Stage 1 (en high): register mode, control_data, data_island_data, and per lane q_m[8:0] plus N1 = popcount(q_m[7:0]).
- q_m: N1D = popcount(video_data). If N1D>4, or N1D==4 and d[0]==0: q_m[0]=d[0], q_m[i]=q_m[i-1] XNOR d[i], q_m[8]=0; else use XOR, q_m[8]=1.
- Stage 2 (en high): compute and register tmds from stage-1 values. Latency is 2 enabled edges from input to tmds. out_valid sets on the second enabled edge after reset and stays high.
- Video (stage-1 mode 1), acc = lane disparity, N0 = 8-N1:
  - acc==0 or N1==N0: out={~q_m8,q_m8,q_m8?q_m[7:0]:~q_m[7:0]}; add = q_m8?(N1-N0):(N0-N1).
  - (acc>0 and N1>N0) or (acc<0 and N1<N0): out={1,q_m8,~q_m[7:0]}; add=(N0-N1)+(q_m8?2:0).
  - else: out={0,q_m8,q_m[7:0]}; add=(N1-N0)-(q_m8?0:2).
  - acc <= acc+add, 5-bit signed.
- Any non-video stage-1 mode clears acc to 0 on that edge.
- Control: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- TERC4 0..F: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- Video guard band: CN 0,2 → 1011001100; CN 1 → 0100110011.
- Data guard band: CN 1,2 → 0100110011. CN 0 uses the lane's stage-1 control_data: 00→1010001110, 01→1001110001, 10→0101100011, 11→1011000011.
- Reserved modes 5..7: tmds holds its previous value; acc cleared.
- disparity_err[k] sets on an enabled edge when the newly written |acc| > DISP_LIMIT. clear_err clears it. If set and clear coincide, set wins.
- en low: tmds, acc, out_valid, flags and stage-1 registers all hold. clear_err is ignored.
- reset_n asserted mid-stream: immediate return to reset values; no residue survives.

Test Plan:
- Reset, then mode=0 with control_data lane0=01: after 2 edges lane0 tmds=0010101011, other lanes with control 00 = 1101010100, out_valid=1.
- Video, lane0 data 0x00 for 2 pixels: tmds 0100000000 (disparity→-8), then 1111111111 (disparity→+2).
- Video to mode 2 to mode 4 with lane0 control 10: lane0 1011001100 then 0101100011; lane1 0100110011 then 0100110011; lane0 disparity reads 0 after the guard band.
- TERC4 sweep 0..F on all lanes: each matches the table 2 edges later; a mode-5 insertion repeats the prior symbol.
- en held low 3 cycles mid-video: tmds and disparity frozen; resume yields the same sequence as an unstalled run. With DISP_LIMIT=1, 0x00,0x00 sets disparity_err; clear_err clears it.
- reset_n pulsed asynchronously between edges mid-video: tmds=1101010100 and out_valid=0 immediately.
